frame_buffer_scroll: RTL

//  Single-clock, parametrised character/attribute frame buffer for the VGA text path.

---
 rtl/frame_buffer_scroll.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/frame_buffer_scroll.sv
// Character/attribute frame buffer: processor port A, scrolled and pipelined display port B, and a fill engine.
// Optional per-byte processor write enables are selected with `define FB_BYTE_WE_EN.
module frame_buffer_scroll #(
  parameter int DATA_WIDTH = 16,
  parameter int COLS       = 100,
  parameter int ROWS       = 75,
  parameter int ADDR_WIDTH = 13,
  parameter int ROW_WIDTH  = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   processor_addr,
  input  logic [DATA_WIDTH-1:0]   processor_din,
`ifdef FB_BYTE_WE_EN
  input  logic [DATA_WIDTH/8-1:0] processor_be,
`endif
  input  logic                    processor_we,
  output logic [DATA_WIDTH-1:0]   processor_dout,
  input  logic                    scroll_we,
  input  logic [ROW_WIDTH-1:0]    scroll_row,
  input  logic                    clear_start,
  input  logic [DATA_WIDTH-1:0]   clear_data,
  output logic                    busy,
  input  logic                    display_en,
  input  logic [ADDR_WIDTH-1:0]   display_addr,
  output logic [DATA_WIDTH-1:0]   display_dout,
  output logic                    display_valid
);

  localparam int DEPTH    = COLS * ROWS;
  localparam int MEM_SIZE = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ROW_WIDTH:0]    ROWS_X   = (ROW_WIDTH + 1)'(ROWS);
`ifdef FB_BYTE_WE_EN
  localparam int NBYTES = DATA_WIDTH / 8;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] fill_q;
  logic                  fill_load;
  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] offset_q;
  logic [DATA_WIDTH-1:0] pdout_q;
  logic                  proc_in_range;
  logic                  proc_wr;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] phys_p1;
  logic                  oor_p1;
  logic [DATA_WIDTH-1:0] ddout_p2;
  logic                  vld_p2;

  // Offset is always below DEPTH, so one conditional subtraction folds the sum back into range.
  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH:0] sum);
    logic [ADDR_WIDTH:0] folded;
    folded = (sum >= DEPTH_X) ? (sum - DEPTH_X) : sum;
    return folded[ADDR_WIDTH-1:0];
  endfunction

  assign proc_in_range = ({1'b0, processor_addr} < DEPTH_X);
  assign proc_wr       = processor_we && (state_q == IDLE) && proc_in_range;
  assign busy          = (state_q == CLEAR);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    fill_we   = 1'b0;
    fill_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          fill_load = 1'b1;
          ptr_d     = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        fill_we = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_load) fill_q <= clear_data;
  end

  // Single write port: the fill engine owns it while busy, processor writes are dropped meanwhile.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[ptr_q] <= fill_q;
    end else if (proc_wr) begin
`ifdef FB_BYTE_WE_EN
      for (int b = 0; b < NBYTES; b++) begin
        if (processor_be[b]) mem[processor_addr][8*b +: 8] <= processor_din[8*b +: 8];
      end
`else
      mem[processor_addr] <= processor_din;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pdout_q  <= '0;
      offset_q <= '0;
    end else begin
      pdout_q <= proc_in_range ? mem[processor_addr] : '0;
      if (scroll_we && ({1'b0, scroll_row} < ROWS_X))
        offset_q <= ADDR_WIDTH'(int'(scroll_row) * COLS);
    end
  end

  assign processor_dout = pdout_q;

  // Stage 1: logical-to-physical address translation
  always_ff @(posedge clk) begin
    phys_p1 <= wrap_addr({1'b0, display_addr} + {1'b0, offset_q});
    oor_p1  <= ({1'b0, display_addr} >= DEPTH_X);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= display_en;
  end

  // Stage 2: RAM read, output held between valid requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ddout_p2 <= '0;
      vld_p2   <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) ddout_p2 <= oor_p1 ? '0 : mem[phys_p1];
    end
  end

  assign display_dout  = ddout_p2;
  assign display_valid = vld_p2;

endmodule
